wb_port_sched: RTL and testbench
================================

WB_PORT_SCHED -- requirements
Module: wb_port_sched

Interface
REQ-001 Signal names and defaults:
- DEPTH, 2, ALU write-back buffer entries; fixed, not a parameter.
- DW, 16, data width.
- RW, 3, register index width.

REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  clock; one clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- alu_valid  in  1  pipeline write-back request (ALU/PC+2/compare result).
- alu_reg  in  3  destination register of ALU request.
- alu_data  in  16  write data of ALU request.
- alu_stall  out  1  backpressure to pipeline; request not accepted this cycle.
- mem_valid  in  1  load-return write request from the multi-cycle memory; never stallable.
- mem_reg  in  3  destination register of the load return.
- mem_data  in  16  load-return data.
- RegWrite  out  1  register-file write enable.
- WrtReg  out  3  register-file write index.
- WrtData  out  16  register-file write data.
- byp_reg  in  3  bypass lookup index.
- byp_hit  out  1  byp_reg matches a buffered entry.
- byp_data  out  16  data of the youngest matching buffered entry.
- buf_cnt  out  2  buffered entry count, 0..2.

Function
REQ-003 A single register-file write port SHALL be shared between the memory return and ALU requests; at most one write per cycle.
REQ-004 Write-port selection SHALL be combinational, same cycle, priority order:
- (1) mem_valid: write mem_reg/mem_data.
- (2) else buffer non-empty: write the head entry and pop it.
- (3) else accepted alu_valid: write alu_reg/alu_data directly, with no buffering.
- (4) else RegWrite=0, WrtReg=0, WrtData=0.
REQ-005 alu_stall SHALL equal (buf_cnt==2); the value is derived from registered state only.
REQ-006 An ALU request SHALL be accepted iff alu_valid && !alu_stall.
REQ-007 An accepted request not written per REQ-004(3) SHALL be pushed at the buffer tail in the same edge.
REQ-008 The upstream pipeline holds alu_valid/alu_reg/alu_data stable while alu_stall is high; the block SHALL NOT latch unaccepted requests.
REQ-009 Buffer state machine:
- States EMPTY (0), ONE (1), FULL (2); encoded by buf_cnt.
- Transitions: count_next = count + push - pop, where pop = (!mem_valid && count>0).
REQ-010 Simultaneous push and pop in ONE SHALL leave count at 1; the old head is written and the new entry becomes the head.
REQ-011 mem_valid in FULL SHALL pop nothing and accept nothing; state stays FULL.
REQ-012 The buffer SHALL be FIFO; write order of ALU requests equals acceptance order.
REQ-013 A memory return is always older than every buffered or incoming ALU request; memory-first ordering is therefore architecturally correct and no entry is squashed.
REQ-014 Bypass lookup:
- byp_hit/byp_data SHALL be combinational over current buffer contents only, excluding this cycle's inputs.
- The youngest matching entry wins.
- byp_data=0 when there is no hit.
REQ-015 Storage SHALL be a 2-entry circular buffer with 1-bit head/tail pointers that wrap modulo 2.
REQ-016 No overflow or underflow SHALL be reachable: pushes are blocked in FULL, and pops only occur when count>0.

Reset
REQ-017 With rst high at an edge, the block SHALL clear:
- buf_cnt=0
- head/tail pointers=0
- entry valid state
REQ-018 During and after reset:
- alu_stall=0 and byp_hit=0.
- The write-port outputs follow REQ-004 on current inputs.
REQ-019 Reset asserted mid-operation SHALL discard buffered entries without writing them.

Verification
REQ-020 Idle to direct write:
- Stimulus: alu_valid=1, reg 3, data 0x1234, no mem.
- Response: same cycle RegWrite=1, WrtReg=3, WrtData=0x1234; buf_cnt stays 0.
REQ-021 Conflict buffering:
- Stimulus: mem 5/0xAAAA and alu 2/0x0001 in the same cycle.
- Response: the mem write occurs; buf_cnt=1.
- Next cycle, no inputs: write 2/0x0001; buf_cnt=0.
REQ-022 Fill and stall:
- Stimulus: three consecutive cycles with mem_valid and alu_valid.
- Response: buf_cnt goes 1, 2; alu_stall=1 in the third cycle; the third request is held.
- After mem drops: the two entries drain in order, then the held request is accepted.
REQ-023 Push/pop in ONE:
- Stimulus: buf_cnt=1 holding 4/0x0BEE; alu 6/0x0C0D, no mem.
- Response: write 4/0x0BEE; buf_cnt stays 1 with head 6/0x0C0D.
REQ-024 Bypass:
- Stimulus: buffer holds 1/0x1111 (old) and 1/0x2222 (young); byp_reg=1.
- Response: byp_hit=1, byp_data=0x2222.
- With byp_reg=7: byp_hit=0, byp_data=0.
REQ-025 Reset mid-operation:
- Stimulus: FULL buffer, rst pulse for 1 cycle.
- Response: buf_cnt=0, alu_stall=0, no buffered entry is ever written.

Source files
------------

// File: rtl/wb_port_sched.sv
// Shared register-file write port: memory returns win, ALU results wait in a
// 2-entry FIFO that can be forwarded from (youngest match) while buffered.
module wb_port_sched (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   input  logic [2:0]  alu_reg,
   input  logic [15:0] alu_data,
   output logic        alu_stall,
   input  logic        mem_valid,
   input  logic [2:0]  mem_reg,
   input  logic [15:0] mem_data,
   output logic        RegWrite,
   output logic [2:0]  WrtReg,
   output logic [15:0] WrtData,
   input  logic [2:0]  byp_reg,
   output logic        byp_hit,
   output logic [15:0] byp_data,
   output logic [1:0]  buf_cnt
);

   typedef struct packed {
      logic [2:0]  rg;
      logic [15:0] data;
   } wb_entry_t;

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   state_t     state, state_nxt;
   wb_entry_t  ent [2];
   logic [1:0] ent_vld;
   logic       head, tail;
   logic       buf_live, accept, pop, push;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   // next-state: count + push - pop
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (push) state_nxt = ONE;
         ONE:     if (push && !pop) state_nxt = FULL;
                  else if (!push && pop) state_nxt = EMPTY;
         FULL:    if (pop) state_nxt = ONE;
         default: state_nxt = EMPTY;
      endcase
   end

   // outputs; while rst is high the buffer is treated as already discarded
   always_comb begin
      buf_live  = (state != EMPTY) && !rst;
      alu_stall = (state == FULL) && !rst;
      accept    = alu_valid && !alu_stall;
      pop       = !mem_valid && buf_live;
      push      = accept && (mem_valid || buf_live);
      RegWrite  = 1'b0;
      WrtReg    = '0;
      WrtData   = '0;
      if (mem_valid) begin
         RegWrite = 1'b1;
         WrtReg   = mem_reg;
         WrtData  = mem_data;
      end else if (buf_live) begin
         RegWrite = 1'b1;
         WrtReg   = ent[head].rg;
         WrtData  = ent[head].data;
      end else if (accept) begin
         RegWrite = 1'b1;
         WrtReg   = alu_reg;
         WrtData  = alu_data;
      end
   end

   // youngest entry sits just behind tail; the other slot is the older one
   always_comb begin
      byp_hit  = 1'b0;
      byp_data = '0;
      if (!rst) begin
         if (ent_vld[~tail] && ent[~tail].rg == byp_reg) begin
            byp_hit  = 1'b1;
            byp_data = ent[~tail].data;
         end else if (ent_vld[tail] && ent[tail].rg == byp_reg) begin
            byp_hit  = 1'b1;
            byp_data = ent[tail].data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head    <= 1'b0;
         tail    <= 1'b0;
         ent_vld <= '0;
      end else begin
         if (pop) begin
            ent_vld[head] <= 1'b0;
            head          <= ~head;
         end
         if (push) begin
            ent[tail]     <= '{rg: alu_reg, data: alu_data};
            ent_vld[tail] <= 1'b1;
            tail          <= ~tail;
         end
      end
   end

   assign buf_cnt = state;

endmodule

// File: tb/tb_wb_port_sched.sv
// Directed and random stimulus for wb_port_sched against a queue-based model
// of the write-port priority rules and FIFO buffering.
module tb_wb_port_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [2:0]  alu_reg;
   logic [15:0] alu_data;
   logic        alu_stall;
   logic        mem_valid;
   logic [2:0]  mem_reg;
   logic [15:0] mem_data;
   logic        RegWrite;
   logic [2:0]  WrtReg;
   logic [15:0] WrtData;
   logic [2:0]  byp_reg;
   logic        byp_hit;
   logic [15:0] byp_data;
   logic [1:0]  buf_cnt;

   int vecs = 0;
   int errs = 0;

   typedef struct {
      logic [2:0]  r;
      logic [15:0] d;
   } ent_t;
   ent_t q[$];
   logic last_stall;

   always #5 clk = ~clk;

   wb_port_sched dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_stall(alu_stall),
      .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data),
      .RegWrite(RegWrite), .WrtReg(WrtReg), .WrtData(WrtData),
      .byp_reg(byp_reg), .byp_hit(byp_hit), .byp_data(byp_data), .buf_cnt(buf_cnt)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: apply inputs, compare against model, advance model across the edge.
   task automatic step(input logic r, input logic av, input logic [2:0] ar, input logic [15:0] ad,
                       input logic mv, input logic [2:0] mr, input logic [15:0] md,
                       input logic [2:0] br);
      int          n;
      logic        e_stall, acc, e_we, e_hit;
      logic [2:0]  e_reg;
      logic [15:0] e_dat, e_byp;
      @(negedge clk);
      rst = r; alu_valid = av; alu_reg = ar; alu_data = ad;
      mem_valid = mv; mem_reg = mr; mem_data = md; byp_reg = br;
      #1;
      n       = r ? 0 : q.size();
      e_stall = (n == 2);
      acc     = av && !e_stall;
      e_we = 1'b0; e_reg = '0; e_dat = '0;
      if (mv)          begin e_we = 1'b1; e_reg = mr;      e_dat = md;      end
      else if (n > 0)  begin e_we = 1'b1; e_reg = q[0].r;  e_dat = q[0].d;  end
      else if (acc)    begin e_we = 1'b1; e_reg = ar;      e_dat = ad;      end
      e_hit = 1'b0; e_byp = '0;
      for (int i = n - 1; i >= 0; i--)
         if (!e_hit && q[i].r == br) begin e_hit = 1'b1; e_byp = q[i].d; end
      check("RegWrite",  16'(RegWrite),  16'(e_we));
      check("WrtReg",    16'(WrtReg),    16'(e_reg));
      check("WrtData",   WrtData,        e_dat);
      check("alu_stall", 16'(alu_stall), 16'(e_stall));
      check("byp_hit",   16'(byp_hit),   16'(e_hit));
      check("byp_data",  byp_data,       e_byp);
      check("buf_cnt",   16'(buf_cnt),   16'(q.size()));
      last_stall = av && e_stall;
      if (r) q.delete();
      else begin
         if (!mv && n > 0) void'(q.pop_front());
         if (acc && (mv || n > 0)) q.push_back('{r: ar, d: ad});
      end
      @(posedge clk);
   endtask

   initial begin
      logic        av, mv, r;
      logic [2:0]  ar, mr, br;
      logic [15:0] ad, md;
      rst = 1'b1; alu_valid = 0; alu_reg = 0; alu_data = 0;
      mem_valid = 0; mem_reg = 0; mem_data = 0; byp_reg = 0;
      last_stall = 1'b0;

      // reset
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      // idle direct write
      step(0, 1, 3, 16'h1234, 0, 0, 0, 3);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      // conflict buffering
      step(0, 1, 2, 16'h0001, 1, 5, 16'hAAAA, 2);
      step(0, 0, 0, 0, 0, 0, 0, 2);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      // fill and stall, then drain and accept the held request
      step(0, 1, 1, 16'h0101, 1, 5, 16'h5001, 1);
      step(0, 1, 2, 16'h0202, 1, 5, 16'h5002, 1);
      step(0, 1, 3, 16'h0303, 1, 5, 16'h5003, 2);
      step(0, 1, 3, 16'h0303, 0, 0, 0, 3);
      step(0, 1, 3, 16'h0303, 0, 0, 0, 3);
      step(0, 0, 0, 0, 0, 0, 0, 3);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      // push/pop in ONE
      step(0, 1, 4, 16'h0BEE, 1, 0, 16'h7777, 4);
      step(0, 1, 6, 16'h0C0D, 0, 0, 0, 4);
      step(0, 0, 0, 0, 0, 0, 0, 6);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      // bypass youngest-wins, miss returns zero
      step(0, 1, 1, 16'h1111, 1, 2, 16'h2020, 1);
      step(0, 1, 1, 16'h2222, 1, 2, 16'h2021, 1);
      step(0, 0, 0, 0, 1, 2, 16'h2022, 1);
      step(0, 0, 0, 0, 1, 2, 16'h2023, 7);
      // reset with FULL buffer discards entries
      step(1, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0);

      // random traffic; a stalled request is held stable until accepted
      av = 0; ar = 0; ad = 0;
      for (int k = 0; k < 400; k++) begin
         if (!last_stall) begin
            av = 1'($urandom_range(0, 1));
            ar = 3'($urandom);
            ad = 16'($urandom);
         end
         mv = ($urandom_range(0, 2) == 0);
         mr = 3'($urandom);
         md = 16'($urandom);
         br = 3'($urandom);
         r  = ($urandom_range(0, 40) == 0);
         step(r, av, ar, ad, mv, mr, md, br);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
